// File: rtl/commit_unit_pkg.sv
// Shared commit-stage types: machine word/pointer widths, thread and register ids,
// TLB write kinds, exception FSM states and the pending-exception queue entry.
package common;
  typedef logic [31:0] word_t;
  typedef logic [31:0] vptr_t;
  typedef logic [19:0] pptr_t;
  typedef logic [19:0] vpn_t;
  typedef logic [7:0]  ppn_t;
  typedef logic [2:0]  threadid_t;
  typedef logic [4:0]  regid_t;

  typedef enum logic [1:0] {TLBW_NONE, TLBW_ITLB, TLBW_DTLB} tlbwrite_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HANDOFF} exc_state_t;

  localparam vptr_t exchandler_pc = 32'h0000_0800;

  // A deferred TLB miss waiting for the current exception master to iret.
  typedef struct packed {
    threadid_t thread;
    vptr_t     pc;
    vpn_t      vpn;
    logic      is_dtlb;
  } pend_t;

  // Faulting page: the fetch page for an itlb miss, the data page otherwise.
  function automatic vpn_t fault_vpn(input logic itlb, input vpn_t pc_page, input vpn_t data_page);
    return itlb ? pc_page : data_page;
  endfunction
endpackage

// File: rtl/commit_unit_fifo.sv
// Pending-exception queue: DEPTH entries, head visible combinationally, registered pointers.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module exc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/commit_unit.sv
// In-order commit per hardware thread with a single-master TLB-miss exception protocol.
// Every output is registered one cycle after the WB slot; enables are one-cycle pulses.
module commit_unit
  import common::*;
#(
  parameter int    N_THREADS  = 8,
  parameter vptr_t PC_RESET   = 32'h1000,
  parameter vptr_t EXC_PC     = common::exchandler_pc,
  parameter int    PEND_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      sup_boot,
  input  logic      wb_valid,
  input  threadid_t wb_thread,
  input  logic      wb_isvalid,
  input  vptr_t     wb_pc,
  input  logic      wb_itlb_miss,
  input  logic      wb_dtlb_miss,
  input  word_t     wb_data,
  input  word_t     wb_r2,
  input  word_t     wb_mul,
  input  regid_t    wb_dst,
  input  logic      wb_flag_reg,
  input  logic      wb_flag_mul,
  input  logic      wb_flag_jump,
  input  logic      wb_flag_branch,
  input  logic      wb_flag_isequal,
  input  logic      wb_flag_store,
  input  logic      wb_flag_isbyte,
  input  logic      wb_flag_iret,
  input  tlbwrite_t wb_flag_tlbwrite,
  input  vptr_t     end_pc,
  output logic      rf_wen,
  output threadid_t rf_thread,
  output regid_t    rf_dst,
  output word_t     rf_wdata,
  output logic      redirect_en,
  output threadid_t redirect_thread,
  output vptr_t     redirect_pc,
  output logic      inval_en,
  output threadid_t inval_thread,
  output logic      store_en,
  output logic      store_isbyte,
  output pptr_t     store_addr,
  output word_t     store_data,
  output logic      itlb_wen,
  output logic      dtlb_wen,
  output vpn_t      tlb_vpn,
  output ppn_t      tlb_ppn,
  output word_t     rm0 [N_THREADS],
  output word_t     rm1 [N_THREADS],
  output word_t     rm2 [N_THREADS],
  output word_t     rm4 [N_THREADS],
  output logic      exc_active,
  output threadid_t exc_master,
  output word_t     retired,
  output logic      done
);
  vptr_t                waiting_pc [N_THREADS];
  logic [N_THREADS-1:0] pending;
  exc_state_t           state;
  logic                 defer_vld;
  threadid_t            defer_thread;

  threadid_t t;
  logic      head, fence_ok, commit, retry, miss, taken, enter_now, all_at_end;
  logic      q_push, q_pop, q_full, q_empty;
  pend_t     push_dat, pop_dat;
  vpn_t      miss_vpn;

  exc_fifo #(.DEPTH(PEND_DEPTH), .W($bits(pend_t))) u_fifo (
    .clk(clk), .rst(rst), .push(q_push), .push_dat(push_dat),
    .pop(q_pop), .head_dat(pop_dat), .full(q_full), .empty(q_empty)
  );

  // The cycle after a deferred handoff redirect owns the redirect port, so WB is ignored.
  always_comb begin
    t         = wb_thread;
    head      = wb_valid && !defer_vld && (wb_pc == waiting_pc[t]);
    fence_ok  = (state == ST_IDLE) || (state == ST_ACTIVE && t == exc_master);
    commit    = head && wb_isvalid && fence_ok;
    retry     = head && !commit;
    miss      = wb_itlb_miss || wb_dtlb_miss;
    taken     = wb_flag_jump && (!wb_flag_branch || wb_flag_isequal);
    enter_now = retry && miss && (state == ST_IDLE);
    q_push    = retry && miss && (state != ST_IDLE) && (t != exc_master) && !pending[t] && !q_full;
    q_pop     = (state == ST_HANDOFF);
    miss_vpn  = fault_vpn(wb_itlb_miss, wb_pc[31:12], wb_data[31:12]);
    push_dat  = '{thread: t, pc: wb_pc, vpn: miss_vpn, is_dtlb: !wb_itlb_miss};
    all_at_end = 1'b1;
    for (int i = 0; i < N_THREADS; i++)
      if (waiting_pc[i] != end_pc) all_at_end = 1'b0;
  end

  assign exc_active = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    rf_wen      <= 1'b0;
    redirect_en <= 1'b0;
    inval_en    <= 1'b0;
    store_en    <= 1'b0;
    itlb_wen    <= 1'b0;
    dtlb_wen    <= 1'b0;
    if (rst) begin
      for (int i = 0; i < N_THREADS; i++) begin
        waiting_pc[i] <= PC_RESET;
        rm0[i] <= '0;
        rm1[i] <= '0;
        rm2[i] <= '0;
        rm4[i] <= {31'b0, sup_boot};
      end
      pending         <= '0;
      state           <= ST_IDLE;
      exc_master      <= '0;
      defer_vld       <= 1'b0;
      defer_thread    <= '0;
      retired         <= '0;
      done            <= 1'b0;
      rf_thread       <= '0;
      rf_dst          <= '0;
      rf_wdata        <= '0;
      redirect_thread <= '0;
      redirect_pc     <= '0;
      inval_thread    <= '0;
      store_isbyte    <= 1'b0;
      store_addr      <= '0;
      store_data      <= '0;
      tlb_vpn         <= '0;
      tlb_ppn         <= '0;
    end else begin
      done <= all_at_end;
      if (defer_vld) begin
        defer_vld       <= 1'b0;
        redirect_en     <= 1'b1;
        redirect_thread <= defer_thread;
        redirect_pc     <= EXC_PC;
        inval_en        <= 1'b1;
        inval_thread    <= defer_thread;
      end

      if (commit) begin
        retired <= retired + 32'd1;
        if (wb_flag_iret) begin
          waiting_pc[t]   <= rm0[t];
          redirect_en     <= 1'b1;
          redirect_thread <= t;
          redirect_pc     <= rm0[t];
          rm4[t]          <= '0;
          if (state == ST_ACTIVE) state <= q_empty ? ST_IDLE : ST_HANDOFF;
        end else if (taken) begin
          waiting_pc[t]   <= wb_data;
          redirect_en     <= 1'b1;
          redirect_thread <= t;
          redirect_pc     <= wb_data;
        end else begin
          waiting_pc[t] <= wb_pc + 32'd4;
        end
        if (wb_flag_reg) begin
          rf_wen    <= 1'b1;
          rf_thread <= t;
          rf_dst    <= wb_dst;
          rf_wdata  <= wb_flag_mul ? wb_mul : wb_data;
        end
        if (wb_flag_store) begin
          store_en     <= 1'b1;
          store_isbyte <= wb_flag_isbyte;
          store_addr   <= wb_data[19:0];
          store_data   <= wb_r2;
        end
        if (wb_flag_tlbwrite != TLBW_NONE) begin
          itlb_wen <= (wb_flag_tlbwrite == TLBW_ITLB);
          dtlb_wen <= (wb_flag_tlbwrite == TLBW_DTLB);
          tlb_vpn  <= wb_data[19:0];
          tlb_ppn  <= wb_r2[7:0];
        end
      end else if (retry) begin
        redirect_en     <= 1'b1;
        redirect_thread <= t;
        redirect_pc     <= enter_now ? EXC_PC : waiting_pc[t];
        inval_en        <= 1'b1;
        inval_thread    <= t;
        if (enter_now) begin
          waiting_pc[t] <= EXC_PC;
          rm0[t]        <= wb_pc;
          rm1[t]        <= {12'b0, miss_vpn};
          rm2[t]        <= {31'b0, !wb_itlb_miss};
          rm4[t]        <= 32'd1;
          state         <= ST_ACTIVE;
          exc_master    <= t;
        end
        if (q_push) pending[t] <= 1'b1;
      end

      // Handoff: the popped thread becomes master; a fenced WB this cycle keeps the redirect port.
      if (state == ST_HANDOFF) begin
        waiting_pc[pop_dat.thread] <= EXC_PC;
        rm0[pop_dat.thread]        <= pop_dat.pc;
        rm1[pop_dat.thread]        <= {12'b0, pop_dat.vpn};
        rm2[pop_dat.thread]        <= {31'b0, pop_dat.is_dtlb};
        rm4[pop_dat.thread]        <= 32'd1;
        pending[pop_dat.thread]    <= 1'b0;
        exc_master                 <= pop_dat.thread;
        state                      <= ST_ACTIVE;
        if (retry) begin
          defer_vld    <= 1'b1;
          defer_thread <= pop_dat.thread;
        end else begin
          redirect_en     <= 1'b1;
          redirect_thread <= pop_dat.thread;
          redirect_pc     <= EXC_PC;
          inval_en        <= 1'b1;
          inval_thread    <= pop_dat.thread;
        end
      end
    end
  end
endmodule
